pc_unit: RTL and testbench

Program-counter and control-flow sequencer for the single-cycle MIPS core, sitting directly downstream of the ALU/instruction decoder. It consumes the decoder's IsJR and IsSyscall flags plus the jump/branch resolution, selects and registers the next PC, executes the syscall side effects (halt on exit, latch display value), and keeps cycle and retired-instruction counters for the board display.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/pc_unit_if.sv | 28 ++
 rtl/pc_next_mux.sv | 27 ++
 rtl/pc_unit.sv | 87 ++++++++
 tb/tb_pc_unit.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants and encodings for the MIPS PC/control-flow sequencer.
package mips_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned JIDX_W   = 26;

  localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_EXIT_CODE = 32'd10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_SEQ  = 3'd1,
    SEL_JR   = 3'd2,
    SEL_J    = 3'd3,
    SEL_BR   = 3'd4
  } pc_sel_e;

  // Word-offset immediate to a sign-extended byte offset.
  function automatic logic [XLEN-1:0] br_offset(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Decoder-to-sequencer bus: control flags and operands in, PC/status out.
interface pc_unit_if;
  logic        IsJR;
  logic        IsSyscall;
  logic        IsJ;
  logic        BranchTaken;
  logic [15:0] Imm16;
  logic [25:0] JTarget;
  logic [31:0] RsData;
  logic [31:0] V0;
  logic [31:0] A0;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Halted;
  logic [31:0] Disp;
  logic [31:0] CycleCnt;
  logic [31:0] InstrCnt;

  modport master (
    output IsJR, IsSyscall, IsJ, BranchTaken, Imm16, JTarget, RsData, V0, A0,
    input  PC, PCPlus4, Halted, Disp, CycleCnt, InstrCnt
  );

  modport slave (
    input  IsJR, IsSyscall, IsJ, BranchTaken, Imm16, JTarget, RsData, V0, A0,
    output PC, PCPlus4, Halted, Disp, CycleCnt, InstrCnt
  );
endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC datapath: selects and computes the next PC from a select code.
module pc_next_mux
  import mips_pkg::*;
(
  input  pc_sel_e     sel_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] rs_data_i,
  input  logic [25:0] j_target_i,
  input  logic [15:0] imm16_i,
  output logic [31:0] next_pc_c
);

  // Target computation per select; jr targets are forced word-aligned.
  always_comb begin
    next_pc_c = pc_i;
    case (sel_i)
      SEL_HOLD: next_pc_c = pc_i;
      SEL_SEQ:  next_pc_c = pc_plus4_i;
      SEL_JR:   next_pc_c = rs_data_i & ~32'h0000_0003;
      SEL_J:    next_pc_c = {pc_plus4_i[31:28], j_target_i, 2'b00};
      SEL_BR:   next_pc_c = pc_plus4_i + br_offset(imm16_i);
      default:  next_pc_c = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// PC register, RUN/HALT sequencer, syscall side effects and performance counters.
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] EXIT_CODE = DEF_EXIT_CODE
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] disp_q, disp_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] instr_q, instr_d;
  pc_sel_e     pc_sel;
  logic [31:0] pc_plus4_c;
  logic [31:0] next_pc_c;

  assign pc_plus4_c = pc_q + 32'd4;

  pc_next_mux u_mux (
    .sel_i      (pc_sel),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4_c),
    .rs_data_i  (bus.RsData),
    .j_target_i (bus.JTarget),
    .imm16_i    (bus.Imm16),
    .next_pc_c  (next_pc_c)
  );

  // Next-state, select priority and side effects; HALT holds everything.
  always_comb begin
    state_d = state_q;
    pc_sel  = SEL_HOLD;
    disp_d  = disp_q;
    cyc_d   = cyc_q;
    instr_d = instr_q;
    if (state_q == RUN) begin
      cyc_d = cyc_q + 32'd1;
      if (bus.IsSyscall) begin
        if (bus.V0 == EXIT_CODE) begin
          state_d = HALT;
          pc_sel  = SEL_HOLD;
        end else begin
          pc_sel  = SEL_SEQ;
          disp_d  = bus.A0;
          instr_d = instr_q + 32'd1;
        end
      end else begin
        instr_d = instr_q + 32'd1;
        if (bus.IsJR)             pc_sel = SEL_JR;
        else if (bus.IsJ)         pc_sel = SEL_J;
        else if (bus.BranchTaken) pc_sel = SEL_BR;
        else                      pc_sel = SEL_SEQ;
      end
    end
    pc_d = next_pc_c;
  end

  // State, PC, display and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      disp_q  <= 32'd0;
      cyc_q   <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      disp_q  <= disp_d;
      cyc_q   <= cyc_d;
      instr_q <= instr_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.PCPlus4  = pc_plus4_c;
  assign bus.Halted   = (state_q == HALT);
  assign bus.Disp     = disp_q;
  assign bus.CycleCnt = cyc_q;
  assign bus.InstrCnt = instr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver pushes model predictions, monitor pops and compares.
module tb_pc_unit;

  typedef struct {
    logic [31:0] pc;
    logic        halted;
    logic [31:0] disp;
    logic [31:0] cyc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if bus();

  pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  exp_t m;
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_check = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference behaviour written from the architectural rules.
  task automatic model(input logic r, input logic sys, input logic jr, input logic j,
                       input logic br, input logic [15:0] imm, input logic [25:0] jt,
                       input logic [31:0] rs, input logic [31:0] v0, input logic [31:0] a0);
    logic [31:0] seq;
    int signed   off;
    if (r) begin
      m.pc = 32'h0000_3000; m.halted = 1'b0; m.disp = 0; m.cyc = 0; m.instr = 0;
    end else if (!m.halted) begin
      m.cyc = m.cyc + 1;
      seq = m.pc + 4;
      if (sys && v0 == 32'd10) begin
        m.halted = 1'b1;
      end else begin
        m.instr = m.instr + 1;
        if (sys) begin
          m.disp = a0;
          m.pc   = seq;
        end else if (jr) begin
          m.pc = (rs / 4) * 4;
        end else if (j) begin
          m.pc = (seq & 32'hF000_0000) + {6'd0, jt} * 4;
        end else if (br) begin
          off  = int'($signed(imm)) * 4;
          m.pc = seq + 32'(off);
        end else begin
          m.pc = seq;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic sys, input logic jr, input logic j,
                       input logic br, input logic [15:0] imm, input logic [25:0] jt,
                       input logic [31:0] rs, input logic [31:0] v0, input logic [31:0] a0);
    @(negedge clk);
    rst = r;
    bus.IsSyscall = sys; bus.IsJR = jr; bus.IsJ = j; bus.BranchTaken = br;
    bus.Imm16 = imm; bus.JTarget = jt; bus.RsData = rs; bus.V0 = v0; bus.A0 = a0;
    model(r, sys, jr, j, br, imm, jt, rs, v0, a0);
    q.push_back(m);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic rand_cycle(input logic allow_rst);
    logic r;
    logic sys;
    logic [31:0] v0;
    r   = allow_rst && ($urandom_range(0, 59) == 0);
    sys = ($urandom_range(0, 7) == 0);
    v0  = ($urandom_range(0, 1) == 0) ? 32'd10 : $urandom;
    drive(r, sys, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
          26'($urandom), $urandom, v0, $urandom);
  endtask

  // Monitor: every clock the DUT presents its registered state; compare against the head.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("PC",       bus.PC,              mon_e.pc);
      chk("PCPlus4",  bus.PCPlus4,         mon_e.pc + 32'd4);
      chk("Halted",   {31'd0, bus.Halted}, {31'd0, mon_e.halted});
      chk("Disp",     bus.Disp,            mon_e.disp);
      chk("CycleCnt", bus.CycleCnt,        mon_e.cyc);
      chk("InstrCnt", bus.InstrCnt,        mon_e.instr);
    end
  end

  initial begin
    int halt_len;
    bus.IsSyscall = 1'b0; bus.IsJR = 1'b0; bus.IsJ = 1'b0; bus.BranchTaken = 1'b0;
    bus.Imm16 = '0; bus.JTarget = '0; bus.RsData = '0; bus.V0 = '0; bus.A0 = '0;
    m = '{pc: 32'h0, halted: 1'b0, disp: 32'h0, cyc: 32'h0, instr: 32'h0};

    // Reset and sequential stepping to 0x3010.
    do_reset();
    repeat (4) idle();
    // Backward and forward branches from 0x3010.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFC, 26'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_3010, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 26'h0, 32'h0, 32'h0, 32'h0);
    // Jump from 0x3000, then jr beating j with masked low bits.
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000C40, 32'h0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 26'h0000C40, 32'h0000_3203, 32'h0, 32'h0);
    // Non-exit syscall beating jr, then exit syscall beating a branch.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_1000, 32'd34, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 26'h0, 32'h0, 32'd10, 32'h1234_5678);
    // Halt holds under random inputs.
    repeat (20) rand_cycle(1'b0);
    do_reset();
    // Reset coincident with an exit syscall.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 32'd10, 32'h0);
    // Wrap: jr to a misaligned top address, then sequential wrap to 0, backward branch below 0.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFF0, 26'h0, 32'h0, 32'h0, 32'h0);
    // Randomized traffic with occasional resets and forced recovery from long halts.
    do_reset();
    halt_len = 0;
    for (int i = 0; i < 400; i++) begin
      if (m.halted) halt_len++;
      else halt_len = 0;
      if (halt_len > 12) begin
        do_reset();
        halt_len = 0;
      end else begin
        rand_cycle(1'b1);
      end
    end

    repeat (2) @(posedge clk);
    #3;
    chk("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
